// File: rtl/vote_tally_n.sv
// N-candidate vote tally: saturating per-candidate counters, invalid-attempt count and a
// one-candidate-per-cycle winner search on close. Define VOTE_TIE_DETECT_EN to drive tie.
module vote_tally_n #(
  parameter  int NCAND = 4,
  parameter  int CW    = 8,
  localparam int IW    = $clog2(NCAND),
  localparam int TW    = CW + IW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCAND-1:0] voter,
  input  logic             confirm,
  input  logic [1:0]       mode,
  input  logic [IW-1:0]    rd_sel,
  output logic [CW-1:0]    rd_count,
  output logic [TW-1:0]    total,
  output logic [CW-1:0]    invalid_cnt,
  output logic             accepted,
  output logic             overflow,
  output logic             busy,
  output logic             winner_valid,
  output logic [NCAND-1:0] winner,
  output logic [IW-1:0]    winner_idx,
  output logic             tie
);
  localparam logic [1:0]  MODE_VOTE  = 2'b00;
  localparam logic [1:0]  MODE_CLOSE = 2'b01;
  localparam logic [1:0]  MODE_CLEAR = 2'b10;
  localparam logic [IW:0] SCAN_END   = (IW+1)'(NCAND);

  typedef enum logic [1:0] {S_VOTE, S_TALLY, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg [NCAND];
  logic [TW-1:0]     total_reg;
  logic [CW-1:0]     invalid_reg;
  logic              confirm_d_reg;
  logic              accepted_reg;
  logic              overflow_reg;
  logic [IW:0]       scan_reg;
  logic [IW-1:0]     best_idx_reg;
  logic [CW-1:0]     best_val_reg;
  logic [NCAND-1:0]  winner_reg;
  logic [IW-1:0]     winner_idx_reg;
`ifdef VOTE_TIE_DETECT_EN
  logic              tie_r_reg;
  logic              tie_out_reg;
`endif

  logic              rise;
  logic              is_onehot;
  logic [IW-1:0]     vote_idx;
  logic [CW-1:0]     sel_cnt;
  logic [CW-1:0]     scan_cnt;

  assign rise      = confirm & ~confirm_d_reg;
  assign is_onehot = (voter != '0) && ((voter & (voter - 1'b1)) == '0);
  assign sel_cnt   = cnt_reg[vote_idx];
  assign scan_cnt  = cnt_reg[scan_reg[IW-1:0]];

  always_comb begin
    vote_idx = '0;
    for (int i = 0; i < NCAND; i++) begin
      if (voter[i]) vote_idx = i[IW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_VOTE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (mode == MODE_CLEAR) begin
      state_next = S_VOTE;
    end else begin
      case (state_reg)
        S_VOTE:  if (mode == MODE_CLOSE) state_next = S_TALLY;
        S_TALLY: if (scan_reg == SCAN_END) state_next = S_DONE;
        S_DONE:  if (mode == MODE_VOTE) state_next = S_VOTE;
        default: state_next = S_VOTE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCAND; i++) cnt_reg[i] <= '0;
      total_reg      <= '0;
      invalid_reg    <= '0;
      confirm_d_reg  <= 1'b0;
      accepted_reg   <= 1'b0;
      overflow_reg   <= 1'b0;
      scan_reg       <= '0;
      best_idx_reg   <= '0;
      best_val_reg   <= '0;
      winner_reg     <= '0;
      winner_idx_reg <= '0;
`ifdef VOTE_TIE_DETECT_EN
      tie_r_reg      <= 1'b0;
      tie_out_reg    <= 1'b0;
`endif
    end else begin
      confirm_d_reg <= confirm;
      accepted_reg  <= 1'b0;
      if (mode == MODE_CLEAR) begin
        for (int i = 0; i < NCAND; i++) cnt_reg[i] <= '0;
        total_reg      <= '0;
        invalid_reg    <= '0;
        overflow_reg   <= 1'b0;
        winner_reg     <= '0;
        winner_idx_reg <= '0;
`ifdef VOTE_TIE_DETECT_EN
        tie_out_reg    <= 1'b0;
`endif
      end else begin
        case (state_reg)
          S_VOTE: begin
            if (mode == MODE_VOTE && rise) begin
              if (is_onehot && sel_cnt != '1) begin
                cnt_reg[vote_idx] <= sel_cnt + 1'b1;
                total_reg         <= total_reg + 1'b1;
                accepted_reg      <= 1'b1;
              end else begin
                // A vote for a saturated candidate is rejected like a malformed one.
                if (is_onehot) overflow_reg <= 1'b1;
                if (invalid_reg != '1) invalid_reg <= invalid_reg + 1'b1;
              end
            end else if (mode == MODE_CLOSE) begin
              best_idx_reg <= '0;
              best_val_reg <= cnt_reg[0];
              scan_reg     <= (IW+1)'(1);
`ifdef VOTE_TIE_DETECT_EN
              tie_r_reg    <= 1'b0;
`endif
            end
          end
          S_TALLY: begin
            if (scan_reg == SCAN_END) begin
              if (best_val_reg == '0) begin
                winner_reg     <= '0;
                winner_idx_reg <= '0;
`ifdef VOTE_TIE_DETECT_EN
                tie_out_reg    <= 1'b0;
`endif
              end else begin
                winner_reg     <= {{(NCAND-1){1'b0}}, 1'b1} << best_idx_reg;
                winner_idx_reg <= best_idx_reg;
`ifdef VOTE_TIE_DETECT_EN
                tie_out_reg    <= tie_r_reg;
`endif
              end
            end else begin
              // Strict greater-than keeps the lowest index on equal counts.
              if (scan_cnt > best_val_reg) begin
                best_val_reg <= scan_cnt;
                best_idx_reg <= scan_reg[IW-1:0];
`ifdef VOTE_TIE_DETECT_EN
                tie_r_reg    <= 1'b0;
              end else if (scan_cnt == best_val_reg && scan_cnt != '0) begin
                tie_r_reg    <= 1'b1;
`endif
              end
              scan_reg <= scan_reg + 1'b1;
            end
          end
          S_DONE: begin
            if (mode == MODE_VOTE) begin
              winner_reg     <= '0;
              winner_idx_reg <= '0;
`ifdef VOTE_TIE_DETECT_EN
              tie_out_reg    <= 1'b0;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_count     = ({1'b0, rd_sel} < SCAN_END) ? cnt_reg[rd_sel] : '0;
  assign total        = total_reg;
  assign invalid_cnt  = invalid_reg;
  assign accepted     = accepted_reg;
  assign overflow     = overflow_reg;
  assign busy         = (state_reg == S_TALLY);
  assign winner_valid = (state_reg == S_DONE);
  assign winner       = winner_reg;
  assign winner_idx   = winner_idx_reg;
`ifdef VOTE_TIE_DETECT_EN
  assign tie          = tie_out_reg;
`else
  assign tie          = 1'b0;
`endif

endmodule

// File: tb/tb_vote_tally_n.sv
// Scoreboard bench for vote_tally_n: accepted pulses and winner reports are checked by a monitor
// against queued expectations; a CW=2 instance covers counter saturation.
module tb_vote_tally_n;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] voter = '0;
  logic       confirm = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] rd_sel = '0;
  logic [7:0] rd_count;
  logic [9:0] total;
  logic [7:0] invalid_cnt;
  logic       accepted, overflow, busy, winner_valid, tie;
  logic [3:0] winner;
  logic [1:0] winner_idx;

  logic [3:0] voter2 = '0;
  logic       confirm2 = 1'b0;
  logic [1:0] mode2 = 2'b00;
  logic [1:0] rd_sel2 = 2'd2;
  logic [1:0] rd_count2;
  logic [3:0] total2;
  logic [1:0] invalid_cnt2;
  logic       accepted2, overflow2, busy2, winner_valid2, tie2;
  logic [3:0] winner2;
  logic [1:0] winner_idx2;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] w;
    logic [1:0] idx;
    logic       t;
  } res_t;
  res_t res_q[$];
  int   tot_q[$];
  res_t mon_r;
  int   mon_e;
  logic wv_prev = 1'b0;

`ifdef VOTE_TIE_DETECT_EN
  localparam logic TIE_EXP = 1'b1;
`else
  localparam logic TIE_EXP = 1'b0;
`endif

  vote_tally_n #(.NCAND(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .voter(voter), .confirm(confirm), .mode(mode), .rd_sel(rd_sel),
    .rd_count(rd_count), .total(total), .invalid_cnt(invalid_cnt), .accepted(accepted),
    .overflow(overflow), .busy(busy), .winner_valid(winner_valid), .winner(winner),
    .winner_idx(winner_idx), .tie(tie)
  );

  vote_tally_n #(.NCAND(4), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .voter(voter2), .confirm(confirm2), .mode(mode2), .rd_sel(rd_sel2),
    .rd_count(rd_count2), .total(total2), .invalid_cnt(invalid_cnt2), .accepted(accepted2),
    .overflow(overflow2), .busy(busy2), .winner_valid(winner_valid2), .winner(winner2),
    .winner_idx(winner_idx2), .tie(tie2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted pulse and every winner report with the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (accepted) begin
          if (tot_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_accepted: got pulse with total=%0d expected none", total);
          end else begin
            mon_e = tot_q.pop_front();
            check("accepted_total", 32'(total), mon_e);
          end
        end
        if (winner_valid && !wv_prev) begin
          if (res_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_winner: got winner=%b expected none", winner);
          end else begin
            mon_r = res_q.pop_front();
            check("winner", 32'(winner), 32'(mon_r.w));
            check("winner_idx", 32'(winner_idx), 32'(mon_r.idx));
            check("tie", 32'(tie), 32'(mon_r.t));
          end
        end
        wv_prev = winner_valid;
      end
    end
  end

  task automatic vote(input logic [3:0] v, input bit ok, input int exp_total);
    if (ok) tot_q.push_back(exp_total);
    @(negedge clk);
    voter = v;
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
    @(negedge clk);
    $display("vote voter=%b mode=%b total=%0d invalid=%0d", v, mode, total, invalid_cnt);
  endtask

  task automatic vote2(input logic [3:0] v);
    @(negedge clk);
    voter2 = v;
    confirm2 = 1'b1;
    @(negedge clk);
    confirm2 = 1'b0;
    @(negedge clk);
    $display("vote2 voter=%b total=%0d invalid=%0d", v, total2, invalid_cnt2);
  endtask

  task automatic read_cnt(input logic [1:0] idx, input logic [7:0] exp);
    rd_sel = idx;
    #1;
    check($sformatf("rd_count[%0d]", idx), 32'(rd_count), 32'(exp));
  endtask

  task automatic close_vote(input logic [3:0] ew, input logic [1:0] ei, input logic et);
    int n;
    res_t r;
    r.w = ew;
    r.idx = ei;
    r.t = et;
    res_q.push_back(r);
    @(negedge clk);
    mode = 2'b01;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("busy_cycles", 32'(n), 32'd4);
    check("winner_valid_done", 32'(winner_valid), 32'd1);
    $display("close winner=%b idx=%0d tie=%0b", winner, winner_idx, tie);
  endtask

  task automatic reopen();
    @(negedge clk);
    mode = 2'b00;
    @(negedge clk);
    check("reopen_winner_valid", 32'(winner_valid), 32'd0);
    check("reopen_winner", 32'(winner), 32'd0);
  endtask

  task automatic clear_all();
    @(negedge clk);
    mode = 2'b10;
    @(negedge clk);
    mode = 2'b00;
    $display("clear total=%0d invalid=%0d", total, invalid_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_total", 32'(total), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_invalid", 32'(invalid_cnt), 32'd0);
    check("rst_winner_valid", 32'(winner_valid), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    read_cnt(2'd0, 8'd0);

    // Basic tally: counts {1,2,1,0}, candidate 1 wins outright.
    vote(4'b0001, 1, 1);
    vote(4'b0010, 1, 2);
    vote(4'b0010, 1, 3);
    vote(4'b0100, 1, 4);
    check("total_4", 32'(total), 32'd4);
    read_cnt(2'd0, 8'd1);
    read_cnt(2'd1, 8'd2);
    read_cnt(2'd2, 8'd1);
    read_cnt(2'd3, 8'd0);
    close_vote(4'b0010, 2'd1, 1'b0);
    reopen();
    read_cnt(2'd1, 8'd2);
    clear_all();
    check("clear_total", 32'(total), 32'd0);
    read_cnt(2'd1, 8'd0);

    // Equal counts at candidates 0 and 3: lowest index wins.
    vote(4'b0001, 1, 1);
    vote(4'b1000, 1, 2);
    close_vote(4'b0001, 2'd0, TIE_EXP);
    reopen();
    clear_all();

    // Malformed selections only.
    vote(4'b0000, 0, 0);
    vote(4'b0011, 0, 0);
    vote(4'b1111, 0, 0);
    check("invalid_3", 32'(invalid_cnt), 32'd3);
    check("invalid_total", 32'(total), 32'd0);
    close_vote(4'b0000, 2'd0, 1'b0);
    reopen();
    clear_all();
    check("clear_invalid", 32'(invalid_cnt), 32'd0);

    // Abort a tally two cycles in.
    vote(4'b0100, 1, 1);
    @(negedge clk);
    mode = 2'b01;
    @(negedge clk);
    check("abort_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    mode = 2'b10;
    @(negedge clk);
    mode = 2'b00;
    check("abort_busy0", 32'(busy), 32'd0);
    check("abort_wv", 32'(winner_valid), 32'd0);
    check("abort_total", 32'(total), 32'd0);
    read_cnt(2'd2, 8'd0);
    vote(4'b0010, 1, 1);
    read_cnt(2'd1, 8'd1);

    // confirm held high across 00 -> 01 -> 00 produces only the first vote.
    tot_q.push_back(2);
    @(negedge clk);
    voter = 4'b0001;
    confirm = 1'b1;
    repeat (2) @(negedge clk);
    close_vote(4'b0001, 2'd0, TIE_EXP);
    reopen();
    repeat (3) @(negedge clk);
    check("held_total", 32'(total), 32'd2);
    read_cnt(2'd0, 8'd1);
    confirm = 1'b0;
    @(negedge clk);

    // Hold mode ignores rises.
    mode = 2'b11;
    vote(4'b0100, 0, 0);
    vote(4'b0100, 0, 0);
    check("hold_total", 32'(total), 32'd2);
    check("hold_invalid", 32'(invalid_cnt), 32'd0);
    read_cnt(2'd2, 8'd0);
    @(negedge clk);
    mode = 2'b00;

    // Saturation on the narrow instance.
    vote2(4'b0100);
    vote2(4'b0100);
    vote2(4'b0100);
    vote2(4'b0100);
    #1;
    check("sat_cnt2", 32'(rd_count2), 32'd3);
    check("sat_overflow", 32'(overflow2), 32'd1);
    check("sat_invalid", 32'(invalid_cnt2), 32'd1);
    check("sat_total", 32'(total2), 32'd3);
    check("no_overflow_main", 32'(overflow), 32'd0);

    repeat (2) @(negedge clk);
    check("tot_q_empty", 32'(tot_q.size()), 32'd0);
    check("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vote_tally_n.md
# vote_tally_n

Parametrised N-candidate voting tally for the tt_um voting-machine family. It counts one-hot confirmed votes into saturating per-candidate counters and tracks invalid attempts. On close it runs a sequential winner search, one candidate per cycle, and reports a registered winner, a tie flag and totals. It sits between the pad-level input decode (voter, confirm, mode) and the output mux that drives uo_out.

## Interface
- NCAND, 4: number of candidates, legal 2..16; IW = clog2(NCAND), local.
- CW, 8: per-candidate and invalid counter width; TW = CW+IW, local.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset; clears all state.
- voter  in  NCAND  one-hot candidate select; bit i = candidate i.
- confirm  in  1  level input; each 0→1 transition is one vote attempt.
- mode  in  2  00 vote, 01 close/count, 10 clear, 11 hold.
- rd_sel  in  IW  candidate index for count readout.
- rd_count  out  CW  cnt[rd_sel], combinational; 0 if rd_sel ≥ NCAND.
- total  out  TW  accepted votes.
- invalid_cnt  out  CW  rejected attempts, saturating.
- accepted  out  1  one-cycle pulse per counted vote.
- overflow  out  1  sticky; a vote hit a saturated counter.
- busy  out  1  high in TALLY.
- winner_valid  out  1  high in DONE (voting complete).
- winner  out  NCAND  one-hot winner; 0 when no votes or not DONE.
- winner_idx  out  IW  winner index; 0 when not DONE.
- tie  out  1  (VOTE_TIE_DETECT_EN) top count shared by ≥2 candidates.

## Operation
- Reset: all counters, total, invalid_cnt, and confirm_d are 0; all outputs are 0; state is VOTE.
- Edge detect: confirm_d <= confirm on every cycle in every state; rise = confirm & ~confirm_d.
- The FSM has three states: VOTE, TALLY, DONE.
- VOTE, mode 00, on rise:
  - voter one-hot and cnt[i] < 2^CW−1: cnt[i]++, total++, accepted is pulsed.
  - voter one-hot and cnt[i] saturated: nothing is counted; overflow is set and invalid_cnt++.
  - voter not one-hot (including 0): invalid_cnt++ (saturating).
- VOTE, mode 11: all rises are ignored and no state changes.
- VOTE, mode 01: go to TALLY.
  - Load best_idx=0, best_val=cnt[0], scan=1, tie_r=0.
- TALLY: each cycle compare cnt[scan] with best_val.
  - Greater: update best, clear tie_r.
  - Equal and nonzero: set tie_r.
  - After comparing index NCAND−1, register winner outputs and go to DONE.
  - Strict > comparison, so the lowest index wins on a tie.
  - mode and rises are ignored, except mode 10.
- DONE: winner_valid=1.
  - If best_val == 0: winner=0, winner_idx=0, tie=0.
  - mode 00: go to VOTE; winner outputs clear; counts are kept.
  - mode 01 or 11: stay.
- mode 10 in any state: clear counters, total, invalid_cnt, overflow and winner outputs; go to VOTE. This aborts a TALLY in progress.
- Rises during TALLY or DONE are dropped, not queued.
- Arithmetic: counters saturate at 2^CW−1; total never wraps (TW bits suffice).

## Timing
- A rise sampled at edge k updates the counters at edge k. accepted is high for the cycle after edge k. rd_count reflects the new value after edge k.
- Back-to-back votes need confirm low for at least 1 sampled cycle between rises.
- If mode=01 is first sampled at edge t: busy is high from edge t to t+NCAND. winner_valid is high from edge t+NCAND.
- mode=10 sampled at edge c clears state at edge c.
- rst asserted at any point, including mid-TALLY, clears state immediately and asynchronously. The first accepted rise after release needs confirm sampled low once.

## Configuration
- VOTE_TIE_DETECT_EN defined: tie_r is tracked and tie is driven, valid only in DONE.
- VOTE_TIE_DETECT_EN undefined: tie_r logic is omitted and tie is tied to 0. Winner selection is unchanged (lowest index wins).

## Test plan
- Reset, then votes 0001, 0010, 0010, 0100 (NCAND=4) → accepted 4 pulses, total=4, cnt={1,2,1,0}. Then mode=01 → busy for 4 cycles, winner=0010, winner_idx=1, tie=0.
- Votes 0001 and 1000 once each, close → winner=0001, winner_idx=0; tie=1 with macro, 0 without.
- Rises with voter 0000, 0011, 1111 → invalid_cnt=3, total=0, no accepted pulse. Close with no votes → winner_valid=1, winner=0.
- CW=2: 4 votes for candidate 2 → cnt[2]=3, overflow=1, invalid_cnt=1, total=3.
- mode=10 two cycles into TALLY → busy drops the next cycle, all counters 0, state VOTE. A vote then counts normally.
- confirm held high across mode 00→01→00 → no extra vote. Mode 11 with rises → counts unchanged.
